// File: rtl/npc_if.sv
`default_nettype none
// ============================================================================
// Module      : npc_if
// Description : Bundle of the next-PC block's datapath signals (NPC_JALR_EN adds JALR/RS1)
// Revision    : 1.0 - initial release
// ============================================================================
interface npc_if;
    logic [31:0] PC;
    logic        PCSrc;
    logic [31:0] IMMEXT;
    logic        EN;
    logic [31:0] NPC;
    logic        MISALIGN;
    logic [31:0] PC_Q;
    logic        MISALIGN_STICKY;
`ifdef NPC_JALR_EN
    logic        JALR;
    logic [31:0] RS1;
`endif

`ifdef NPC_JALR_EN
    modport master (
        output PC, PCSrc, IMMEXT, EN, JALR, RS1,
        input  NPC, MISALIGN, PC_Q, MISALIGN_STICKY
    );
    modport slave (
        input  PC, PCSrc, IMMEXT, EN, JALR, RS1,
        output NPC, MISALIGN, PC_Q, MISALIGN_STICKY
    );
`else
    modport master (
        output PC, PCSrc, IMMEXT, EN,
        input  NPC, MISALIGN, PC_Q, MISALIGN_STICKY
    );
    modport slave (
        input  PC, PCSrc, IMMEXT, EN,
        output NPC, MISALIGN, PC_Q, MISALIGN_STICKY
    );
`endif
endinterface
`default_nettype wire

// File: rtl/npc.sv
`default_nettype none
// ============================================================================
// Module      : npc
// Description : Next-PC adder with registered PC and sticky misalignment flag.
//               Optional JALR target path enabled by macro NPC_JALR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    npc_if.slave      bus
);

    localparam logic PC_NOJUMP   = 1'b0;
    localparam logic PC_J_OFFSET = 1'b1;

    logic [31:0] next_pc;
    logic        misalign;
    logic [31:0] pc_d;
    logic [31:0] pc_q;
    logic        sticky_d;
    logic        sticky_q;

    // An unknown PCSrc fails the equality test and falls through to PC+4.
    always_comb begin
        next_pc = bus.PC + 32'd4;
        if (bus.PCSrc == PC_J_OFFSET) begin
            next_pc = bus.PC + bus.IMMEXT;
        end
`ifdef NPC_JALR_EN
        if (bus.JALR) begin
            next_pc = (bus.RS1 + bus.IMMEXT) & 32'hFFFF_FFFE;
        end
`endif
        misalign = (next_pc[1:0] != 2'b00);
    end

    always_comb begin
        pc_d     = pc_q;
        sticky_d = sticky_q;
        if (bus.EN) begin
            pc_d     = next_pc;
            sticky_d = sticky_q | misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            sticky_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.NPC             = next_pc;
    assign bus.MISALIGN        = misalign;
    assign bus.PC_Q            = pc_q;
    assign bus.MISALIGN_STICKY = sticky_q;

    // PC_NOJUMP documents the default encoding used above.
    logic unused_enc;
    assign unused_enc = PC_NOJUMP;

endmodule
`default_nettype wire

// File: tb/tb_npc.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc
// Description : Self-checking bench for npc (directed vectors plus random cycles)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

    logic clk;
    logic rst_n;
    npc_if bus ();

    npc #(.RESET_PC(TB_RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_pc_q;
    logic        exp_sticky;
    logic        jalr_v;
    logic [31:0] rs1_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: architectural next-PC rule, 32-bit wrap via truncation.
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic src,
                                            input logic [31:0] imm, input logic jalr,
                                            input logic [31:0] rs1);
        longint unsigned sum;
        if (jalr) begin
            sum = (longint'(rs1) + longint'(imm)) % 64'h1_0000_0000;
            return 32'(sum - (sum % 2));
        end
        if (src === 1'b1) sum = longint'(pc) + longint'(imm);
        else              sum = longint'(pc) + 4;
        return 32'(sum % 64'h1_0000_0000);
    endfunction

    task automatic drive(input logic [31:0] pc, input logic src, input logic [31:0] imm,
                         input logic en);
        bus.PC     = pc;
        bus.PCSrc  = src;
        bus.IMMEXT = imm;
        bus.EN     = en;
`ifdef NPC_JALR_EN
        bus.JALR   = jalr_v;
        bus.RS1    = rs1_v;
`endif
    endtask

    task automatic comb_vec(input string tag, input logic [31:0] pc, input logic src,
                            input logic [31:0] imm, input logic [31:0] exp_npc);
        drive(pc, src, imm, 1'b0);
        #1;
        check({tag, "_npc"}, bus.NPC, exp_npc);
        check({tag, "_mis"}, {31'd0, bus.MISALIGN}, {31'd0, (exp_npc % 4) != 0});
    endtask

    // One full clock: combinational checks, then registered checks after the edge.
    task automatic cycle(input logic rst, input logic en, input logic [31:0] pc,
                         input logic src, input logic [31:0] imm);
        logic [31:0] e;
        @(negedge clk);
        rst_n = rst;
        drive(pc, src, imm, en);
        #1;
        e = ref_npc(pc, src, imm, jalr_v, rs1_v);
        check("npc", bus.NPC, e);
        check("misalign", {31'd0, bus.MISALIGN}, {31'd0, (e % 4) != 0});
        @(posedge clk);
        if (!rst) begin
            exp_pc_q   = TB_RESET_PC;
            exp_sticky = 1'b0;
        end else if (en) begin
            exp_pc_q   = e;
            exp_sticky = exp_sticky || ((e % 4) != 0);
        end
        #1;
        check("pc_q", bus.PC_Q, exp_pc_q);
        check("sticky", {31'd0, bus.MISALIGN_STICKY}, {31'd0, exp_sticky});
    endtask

    initial begin
        logic [31:0] pc_r, imm_r;
        logic        src_r, en_r, rst_r;
        rst_n      = 1'b0;
        jalr_v     = 1'b0;
        rs1_v      = 32'd0;
        exp_pc_q   = TB_RESET_PC;
        exp_sticky = 1'b0;
        drive(32'd0, 1'b0, 32'd0, 1'b0);

        @(negedge clk);
        comb_vec("v030", 32'h0000_0000, 1'b0, 32'h1234_5678, 32'h0000_0004);
        comb_vec("v031", 32'h0000_2000, 1'b1, 32'h0000_0010, 32'h0000_2010);
        @(negedge clk);
        comb_vec("v032", 32'h0000_3000, 1'b1, 32'hFFFF_FFF0, 32'h0000_2FF0);
        comb_vec("v033", 32'h0000_5000, 1'b1, 32'h0000_0000, 32'h0000_5000);
        @(negedge clk);
        comb_vec("v034", 32'hFFFF_FFFC, 1'b0, 32'h0000_0040, 32'h0000_0000);
        comb_vec("srcx", 32'h0000_6000, 1'bx, 32'h0000_0100, 32'h0000_6004);
        @(negedge clk);
        comb_vec("tog0", 32'h0000_7000, 1'b0, 32'h0000_0100, 32'h0000_7004);
        comb_vec("tog1", 32'h0000_7000, 1'b1, 32'h0000_0100, 32'h0000_7100);
        comb_vec("tog2", 32'h0000_7000, 1'b0, 32'h0000_0100, 32'h0000_7004);
`ifdef NPC_JALR_EN
        @(negedge clk);
        jalr_v = 1'b1;
        rs1_v  = 32'h0000_1001;
        comb_vec("jalr", 32'h0000_8000, 1'b1, 32'h0000_0004, 32'h0000_1004);
        jalr_v = 1'b0;
`endif

        // Register scenario: reset, misaligned step, stall, reset with EN high.
        cycle(1'b0, 1'b1, 32'h0000_4000, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, exp_pc_q, 1'b1, 32'h0000_0002);
        check("sc_pcq", bus.PC_Q, TB_RESET_PC + 32'd2);
        cycle(1'b1, 1'b0, exp_pc_q, 1'b0, 32'h0000_0010);
        check("sc_hold", bus.PC_Q, TB_RESET_PC + 32'd2);
        cycle(1'b0, 1'b1, exp_pc_q, 1'b0, 32'h0000_0000);

        for (int i = 0; i < 400; i++) begin
            rst_r = ($urandom_range(0, 19) != 0);
            en_r  = ($urandom_range(0, 3) != 0);
            src_r = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       pc_r = $urandom;
                1:       pc_r = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                default: pc_r = exp_pc_q;
            endcase
            case ($urandom_range(0, 7))
                0:       imm_r = $urandom;
                1, 2, 3: imm_r = 32'hFFFF_F000 | ($urandom & 32'hFFC);
                default: imm_r = $urandom & 32'hFFC;
            endcase
`ifdef NPC_JALR_EN
            jalr_v = ($urandom_range(0, 4) == 0);
            rs1_v  = $urandom;
`endif
            cycle(rst_r, en_r, pc_r, src_r, imm_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/npc.md
NPC -- requirements
Module: npc

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, value loaded into PC_Q on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 Port: PC  input  32  current program counter.
REQ-005 Port: PCSrc  input  1  next-PC select; PC_NOJUMP (1'b0) = PC+4, PC_J_OFFSET (1'b1) = PC+IMMEXT; encodings from the shared define file.
REQ-006 Port: IMMEXT  input  32  sign-extended branch/jump offset, two's complement.
REQ-007 Port: EN  input  1  PC_Q update enable; 0 = stall.
REQ-008 Port: NPC  output  32  combinational next PC.
REQ-009 Port: MISALIGN  output  1  combinational; 1 when NPC[1:0] != 2'b00.
REQ-010 Port: PC_Q  output  32  registered PC; the integrator may feed it back to PC.
REQ-011 Port: MISALIGN_STICKY  output  1  registered sticky misalignment flag.

Function
REQ-012 NPC SHALL equal PC + 32'd4 when PCSrc = 0; IMMEXT is ignored.
REQ-013 NPC SHALL equal PC + IMMEXT when PCSrc = 1.
REQ-014 All additions SHALL be 32-bit modulo 2^32 with the carry discarded (for example, FFFF_FFFC + 4 = 0000_0000, 3000 + FFFF_FFF0 = 2FF0).
REQ-015 NPC and MISALIGN SHALL be purely combinational from PC, PCSrc and IMMEXT, with no clock dependence.
REQ-016 When PCSrc is X or Z, NPC SHALL resolve to PC + 4.
REQ-017 On a rising edge with rst_n = 1 and EN = 1, PC_Q SHALL load NPC.
REQ-018 On a rising edge with EN = 0, PC_Q SHALL hold its value.
REQ-019 On a rising edge with rst_n = 1 and EN = 1, MISALIGN_STICKY SHALL set when MISALIGN = 1.
REQ-020 Once set, MISALIGN_STICKY SHALL stay set until reset.
REQ-021 PC_Q latency SHALL be one cycle from NPC.
REQ-022 The block SHALL have no other pipelining.

Reset
REQ-023 When rst_n = 0 at a rising edge, PC_Q SHALL load RESET_PC and MISALIGN_STICKY SHALL clear to 0.
REQ-024 Reset SHALL take priority over EN.
REQ-025 Reset asserted mid-operation SHALL take effect only at the next clk edge.
REQ-026 NPC and MISALIGN SHALL remain combinational during reset.

Configuration
REQ-027 Macro NPC_JALR_EN SHALL control the JALR feature.
REQ-028 When NPC_JALR_EN is defined:
  - add inputs JALR (1 bit) and RS1 (32 bits);
  - when JALR = 1, NPC = (RS1 + IMMEXT) & 32'hFFFF_FFFE, regardless of PCSrc.
REQ-029 When NPC_JALR_EN is undefined:
  - the JALR and RS1 ports are absent;
  - behaviour is exactly REQ-012 to REQ-026.

Verification
REQ-030 PC=0000_0000, PCSrc=0, IMMEXT=1234_5678 -> NPC=0000_0004, MISALIGN=0.
REQ-031 PC=0000_2000, PCSrc=1, IMMEXT=0000_0010 -> NPC=0000_2010.
REQ-032 PC=0000_3000, PCSrc=1, IMMEXT=FFFF_FFF0 -> NPC=0000_2FF0.
REQ-033 PC=0000_5000, PCSrc=1, IMMEXT=0 -> NPC=0000_5000.
REQ-034 PC=FFFF_FFFC, PCSrc=0 -> NPC=0000_0000 (wrap).
REQ-035 PC=0000_7000, IMMEXT=0000_0100, PCSrc toggled 0/1/0 at 1 ns spacing -> NPC 7004/7100/7004 within each step.
REQ-036 Register scenario:
  - rst_n=0 for one edge -> PC_Q=RESET_PC, MISALIGN_STICKY=0;
  - with EN=1, PCSrc=1, IMMEXT=0000_0002 -> after the edge MISALIGN_STICKY=1 and PC_Q=PC+2;
  - EN=0 -> PC_Q holds.
REQ-037 With NPC_JALR_EN defined: JALR=1, RS1=0000_1001, IMMEXT=0000_0004 -> NPC=0000_1004.
